// File: rtl/edvs_cmd_pkg.sv
// edvs_cmd_pkg: shared types and constants for the eDVS command sequencer.
//   state_t   - sequencer FSM states
//   cmd_id_t  - command identifiers, numbered in priority order (0 = highest)
//   BYTE_*    - ASCII bytes used by the camera commands
//   LEN_*     - command lengths in bytes
//   CNT_*     - shared timeout/gap counter width and constants
package edvs_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_ACK  = 3'd2,
    WAIT_DONE = 3'd3,
    GAP       = 3'd4,
    ERR       = 3'd5
  } state_t;

  // Encoding doubles as the bit position in the pending register.
  typedef enum logic [1:0] {
    CMD_STOP  = 2'd0,
    CMD_RESET = 2'd1,
    CMD_START = 2'd2
  } cmd_id_t;

  localparam logic [7:0] BYTE_E     = 8'h45;  // 'E'
  localparam logic [7:0] BYTE_PLUS  = 8'h2B;  // '+'
  localparam logic [7:0] BYTE_MINUS = 8'h2D;  // '-'
  localparam logic [7:0] BYTE_R     = 8'h52;  // 'R'
  localparam logic [7:0] BYTE_LF    = 8'h0A;  // '\n'

  localparam logic [1:0] LEN_START = 2'd3;
  localparam logic [1:0] LEN_STOP  = 2'd3;
  localparam logic [1:0] LEN_RESET = 2'd2;

  localparam int unsigned CNT_W = 17;
  localparam logic [CNT_W-1:0] CNT_ZERO = 17'd0;
  localparam logic [CNT_W-1:0] CNT_ONE  = 17'd1;
  localparam logic [CNT_W-1:0] CNT_MAX  = 17'h1FFFF;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : (c + CNT_ONE);
  endfunction

endpackage

// File: rtl/edvs_cmd_rom.sv
// edvs_cmd_rom: combinational command byte table.
//   cmd  (in)  - command id
//   idx  (in)  - byte index within the command
//   data (out) - byte to transmit
//   last (out) - high when idx addresses the final byte of the command
// Out-of-range indices return 0x00 flagged as last so a stray index can
// never extend a command.
module edvs_cmd_rom
  import edvs_cmd_pkg::*;
(
  input  cmd_id_t    cmd,
  input  logic [1:0] idx,
  output logic [7:0] data,
  output logic       last
);

  // Byte lookup and last-byte flag per command
  always_comb begin
    data = 8'h00;
    last = 1'b1;
    case (cmd)
      CMD_START: begin
        last = (idx >= (LEN_START - 2'd1));
        case (idx)
          2'd0:    data = BYTE_E;
          2'd1:    data = BYTE_PLUS;
          2'd2:    data = BYTE_LF;
          default: data = 8'h00;
        endcase
      end
      CMD_STOP: begin
        last = (idx >= (LEN_STOP - 2'd1));
        case (idx)
          2'd0:    data = BYTE_E;
          2'd1:    data = BYTE_MINUS;
          2'd2:    data = BYTE_LF;
          default: data = 8'h00;
        endcase
      end
      CMD_RESET: begin
        last = (idx >= (LEN_RESET - 2'd1));
        case (idx)
          2'd0:    data = BYTE_R;
          2'd1:    data = BYTE_LF;
          default: data = 8'h00;
        endcase
      end
      default: begin
        data = 8'h00;
        last = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/edvs_cmd_sequencer.sv
// edvs_cmd_sequencer: serialises eDVS ASCII commands onto the shared UART
// transmitter one byte at a time via the wr_en/tx_busy handshake.
//   clk        (in)  - 50 MHz system clock
//   reset      (in)  - synchronous, active-high
//   start_req  (in)  - pulse, queue "E+\n"
//   stop_req   (in)  - pulse, queue "E-\n"
//   rst_req    (in)  - pulse, queue "R\n"
//   tx_busy    (in)  - transmitter busy
//   tx_data    (out) - byte presented to the transmitter, held until next issue
//   tx_wr_en   (out) - one-cycle write strobe
//   cmd_busy   (out) - high whenever the FSM is not idle
//   cmd_done   (out) - pulse when a command's last byte has completed
//   cmd_err    (out) - pulse when a handshake timed out
//   streaming  (out) - camera has been told to stream
module edvs_cmd_sequencer
  import edvs_cmd_pkg::*;
#(
  parameter int unsigned GAP_CYCLES     = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter bit          INIT_STOP      = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_req,
  input  logic       stop_req,
  input  logic       rst_req,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_wr_en,
  output logic       cmd_busy,
  output logic       cmd_done,
  output logic       cmd_err,
  output logic       streaming
);

  // Thresholds are one/two short of the nominal counts because the counter is
  // cleared on entry and the decision is registered: the cmd_err pulse lands
  // exactly TIMEOUT_CYCLES after the write strobe, and IDLE is reached exactly
  // GAP_CYCLES after the cmd_done/cmd_err pulse.
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 32'd2);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 32'd1);

  state_t           state_r;
  cmd_id_t          cmd_r;
  logic [1:0]       idx_r;
  logic             last_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       pending_r;

  logic [2:0]       req_s;
  logic [2:0]       clear_s;
  cmd_id_t          pick_s;
  logic             launch_s;
  cmd_id_t          rom_cmd_s;
  logic [1:0]       rom_idx_s;
  logic [7:0]       rom_byte_s;
  logic             rom_last_s;

  assign req_s    = {start_req, rst_req, stop_req};
  assign launch_s = (state_r == IDLE) && (|pending_r) && !tx_busy;

  // Fixed priority STOP > RESET > START over the pending bits
  always_comb begin
    if (pending_r[0]) begin
      pick_s = CMD_STOP;
    end else if (pending_r[1]) begin
      pick_s = CMD_RESET;
    end else if (pending_r[2]) begin
      pick_s = CMD_START;
    end else begin
      pick_s = CMD_STOP;
    end
  end

  // Pending bit to drop in the cycle its command leaves IDLE
  always_comb begin
    clear_s = 3'b000;
    if (launch_s) begin
      case (pick_s)
        CMD_STOP:  clear_s = 3'b001;
        CMD_RESET: clear_s = 3'b010;
        CMD_START: clear_s = 3'b100;
        default:   clear_s = 3'b000;
      endcase
    end else begin
      clear_s = 3'b000;
    end
  end

  // ROM address: first byte of the selected command while idle, otherwise the
  // byte after the one in flight (loaded when the current byte completes)
  always_comb begin
    if (state_r == IDLE) begin
      rom_cmd_s = pick_s;
      rom_idx_s = 2'd0;
    end else begin
      rom_cmd_s = cmd_r;
      rom_idx_s = idx_r + 2'd1;
    end
  end

  edvs_cmd_rom u_rom (
    .cmd  (rom_cmd_s),
    .idx  (rom_idx_s),
    .data (rom_byte_s),
    .last (rom_last_s)
  );

  // Pending register; a request in the clearing cycle re-arms its bit
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_r <= {2'b00, INIT_STOP};
    end else begin
      pending_r <= (pending_r & ~clear_s) | req_s;
    end
  end

  // Sequencer FSM with registered outputs and shared saturating counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      cmd_r     <= CMD_STOP;
      idx_r     <= 2'd0;
      last_r    <= 1'b0;
      cnt_r     <= CNT_ZERO;
      tx_data   <= 8'h00;
      tx_wr_en  <= 1'b0;
      cmd_busy  <= 1'b0;
      cmd_done  <= 1'b0;
      cmd_err   <= 1'b0;
      streaming <= 1'b0;
    end else begin
      tx_wr_en <= 1'b0;
      cmd_done <= 1'b0;
      cmd_err  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (launch_s) begin
            cmd_r    <= pick_s;
            idx_r    <= 2'd0;
            tx_data  <= rom_byte_s;
            last_r   <= rom_last_s;
            tx_wr_en <= 1'b1;
            cmd_busy <= 1'b1;
            state_r  <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_r   <= CNT_ZERO;
          state_r <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (tx_busy) begin
            cnt_r   <= CNT_ZERO;
            state_r <= WAIT_DONE;
          end else if (cnt_r >= TO_LAST) begin
            cmd_err <= 1'b1;
            state_r <= ERR;
          end else begin
            cnt_r <= cnt_sat_inc(cnt_r);
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            if (last_r) begin
              cmd_done  <= 1'b1;
              streaming <= (cmd_r == CMD_START);
              cnt_r     <= CNT_ZERO;
              state_r   <= GAP;
            end else begin
              idx_r    <= idx_r + 2'd1;
              tx_data  <= rom_byte_s;
              last_r   <= rom_last_s;
              tx_wr_en <= 1'b1;
              state_r  <= ISSUE;
            end
          end else if (cnt_r >= TO_LAST) begin
            cmd_err <= 1'b1;
            state_r <= ERR;
          end else begin
            cnt_r <= cnt_sat_inc(cnt_r);
          end
        end
        GAP: begin
          if (cnt_r >= GAP_LAST) begin
            cmd_busy <= 1'b0;
            state_r  <= IDLE;
          end else begin
            cnt_r <= cnt_sat_inc(cnt_r);
          end
        end
        ERR: begin
          // The ERR cycle itself is the first gap cycle.
          cnt_r   <= CNT_ONE;
          state_r <= GAP;
        end
        default: begin
          cmd_busy <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_edvs_cmd_sequencer.sv
module tb_edvs_cmd_sequencer;

  localparam int GAP = 50;
  localparam int TO  = 600;

  logic       clk;
  logic       reset;
  logic       start_req;
  logic       stop_req;
  logic       rst_req;
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       tx_wr_en;
  logic       cmd_busy;
  logic       cmd_done;
  logic       cmd_err;
  logic       streaming;

  edvs_cmd_sequencer #(
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TO),
    .INIT_STOP      (1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start_req (start_req),
    .stop_req  (stop_req),
    .rst_req   (rst_req),
    .tx_busy   (tx_busy),
    .tx_data   (tx_data),
    .tx_wr_en  (tx_wr_en),
    .cmd_busy  (cmd_busy),
    .cmd_done  (cmd_done),
    .cmd_err   (cmd_err),
    .streaming (streaming)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] exp_q[$];
  int         wr_cyc_q[$];
  int         done_cyc_q[$];
  int         wr_cnt = 0;
  int         done_cnt = 0;
  int         err_cnt = 0;
  int         err_cyc = 0;
  logic       prev_done = 1'b0;
  logic       stream_after_done = 1'b0;

  logic dead = 1'b0;
  int   hold_cycles = 500;

  typedef struct {
    logic        start;
    logic        stop;
    logic        rst;
    int          n;
    logic [63:0] bytes;
    logic        exp_stream;
    int          exp_dones;
  } vec_t;
  vec_t tbl[6];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Transmitter model: busy rises 2 cycles after a write, holds hold_cycles.
  initial begin
    int dly;
    int left;
    dly = 0;
    left = 0;
    tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        tx_busy = 1'b0;
        dly = 0;
        left = 0;
      end else if (tx_busy) begin
        if (left <= 1) tx_busy = 1'b0;
        else left--;
      end else if (dly > 0) begin
        dly--;
        if (dly == 0) begin
          tx_busy = 1'b1;
          left = hold_cycles;
        end
      end else if (tx_wr_en === 1'b1 && !dead) begin
        dly = 2;
      end
    end
  end

  // Output monitor / scoreboard consumer
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (prev_done) stream_after_done = streaming;
      prev_done = (cmd_done === 1'b1);
      if (tx_wr_en === 1'b1) begin
        wr_cnt++;
        wr_cyc_q.push_back(cyc);
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL byte_unexpected: got %02h required no byte", tx_data);
        end else begin
          e = exp_q.pop_front();
          if (tx_data !== e) begin
            bad++;
            $display("FAIL byte: got %02h required %02h", tx_data, e);
          end
        end
        total++;
        if (tx_busy !== 1'b0) begin
          bad++;
          $display("FAIL wr_while_busy: got tx_busy=%b required 0", tx_busy);
        end
      end
      if (cmd_done === 1'b1) begin
        done_cnt++;
        done_cyc_q.push_back(cyc);
      end
      if (cmd_err === 1'b1) begin
        err_cnt++;
        err_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic push_bytes(input int n, input logic [63:0] b);
    for (int i = 0; i < n; i++) exp_q.push_back(b[63-8*i -: 8]);
  endtask

  task automatic pulse(input logic s, input logic p, input logic r);
    start_req = s;
    stop_req  = p;
    rst_req   = r;
    tick();
    start_req = 1'b0;
    stop_req  = 1'b0;
    rst_req   = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      tick();
      n++;
    end
    if (done_cnt < target) check("wait_done_timeout", done_cnt, target);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    int low;
    n = 0;
    low = 0;
    while (low < 3 && n < budget) begin
      tick();
      n++;
      if (cmd_busy === 1'b0) low++;
      else low = 0;
    end
    if (low < 3) check("wait_idle_timeout", {31'd0, cmd_busy}, 32'd0);
  endtask

  task automatic wait_busy_low(input int budget, output int at_cyc);
    int n;
    n = 0;
    at_cyc = -1;
    while (cmd_busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    if (cmd_busy === 1'b0) at_cyc = cyc;
    else check("wait_busy_low_timeout", {31'd0, cmd_busy}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_data"}, {24'd0, tx_data}, 32'h00);
    check({tag, "_tx_wr_en"}, {31'd0, tx_wr_en}, 32'd0);
    check({tag, "_cmd_busy"}, {31'd0, cmd_busy}, 32'd0);
    check({tag, "_cmd_done"}, {31'd0, cmd_done}, 32'd0);
    check({tag, "_cmd_err"}, {31'd0, cmd_err}, 32'd0);
    check({tag, "_streaming"}, {31'd0, streaming}, 32'd0);
  endtask

  initial begin
    int req_cyc;
    int d0;
    int base;
    int low_cyc;
    int w;

    tbl[0] = '{1'b1, 1'b0, 1'b0, 3, 64'h452B0A00_00000000, 1'b1, 1};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 2, 64'h520A0000_00000000, 1'b0, 1};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 5, 64'h520A452B_0A000000, 1'b1, 2};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 8, 64'h452D0A52_0A452B0A, 1'b1, 3};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 3, 64'h452D0A00_00000000, 1'b0, 1};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 3, 64'h452B0A00_00000000, 1'b1, 1};

    reset = 1'b1;
    start_req = 1'b0;
    stop_req = 1'b0;
    rst_req = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");

    // INIT_STOP: STOP issued after release, slow transmitter
    push_bytes(3, 64'h452D0A00_00000000);
    reset = 1'b0;
    wait_done(1, 5000);
    wait_idle(3000);
    check("init_streaming", {31'd0, streaming}, 32'd0);
    check("init_done_cnt", done_cnt, 1);
    check("init_q_empty", exp_q.size(), 0);

    // Single start: latency and streaming after done
    hold_cycles = 20;
    wr_cyc_q.delete();
    push_bytes(3, 64'h452B0A00_00000000);
    req_cyc = cyc;
    base = done_cnt;
    pulse(1'b1, 1'b0, 1'b0);
    wait_done(base + 1, 2000);
    wait_idle(2000);
    w = (wr_cyc_q.size() > 0) ? wr_cyc_q[0] - req_cyc : -1;
    check("start_latency", w, 2);
    check("start_stream_after_done", {31'd0, stream_after_done}, 32'd1);
    check("start_q_empty", exp_q.size(), 0);

    // Simultaneous start+stop: STOP, exact gap, then START
    wr_cyc_q.delete();
    done_cyc_q.delete();
    push_bytes(6, 64'h452D0A45_2B0A0000);
    base = done_cnt;
    pulse(1'b1, 1'b1, 1'b0);
    wait_done(base + 2, 3000);
    wait_idle(2000);
    check("sim_wr_count", wr_cyc_q.size(), 6);
    d0 = (done_cyc_q.size() > 0) ? done_cyc_q[0] : 0;
    w = (wr_cyc_q.size() > 3) ? wr_cyc_q[3] - d0 : -1;
    check("sim_gap", w, GAP + 1);
    check("sim_streaming", {31'd0, streaming}, 32'd1);
    check("sim_q_empty", exp_q.size(), 0);

    // Re-arm: second start pulse lands in the cycle the bit clears
    push_bytes(6, 64'h452B0A45_2B0A0000);
    base = done_cnt;
    start_req = 1'b1;
    tick();
    tick();
    start_req = 1'b0;
    wait_done(base + 2, 3000);
    wait_idle(2000);
    check("rearm_dones", done_cnt - base, 2);
    check("rearm_q_empty", exp_q.size(), 0);

    // Table-driven request patterns
    for (int k = 0; k < 6; k++) begin
      push_bytes(tbl[k].n, tbl[k].bytes);
      base = done_cnt;
      pulse(tbl[k].start, tbl[k].stop, tbl[k].rst);
      wait_done(base + tbl[k].exp_dones, 4000);
      wait_idle(2000);
      check($sformatf("tbl%0d_streaming", k), {31'd0, streaming}, {31'd0, tbl[k].exp_stream});
      check($sformatf("tbl%0d_dones", k), done_cnt - base, tbl[k].exp_dones);
      check($sformatf("tbl%0d_q_empty", k), exp_q.size(), 0);
    end

    // Timeout: transmitter never answers, streaming is 1 beforehand
    dead = 1'b1;
    base = wr_cnt;
    d0 = err_cnt;
    w = done_cnt;
    push_bytes(1, 64'h45000000_00000000);
    pulse(1'b0, 1'b1, 1'b0);
    for (int n = 0; n < TO + 100 && err_cnt == d0; n++) tick();
    check("to_err_cnt", err_cnt - d0, 1);
    req_cyc = (wr_cyc_q.size() > 0) ? wr_cyc_q[$] : 0;
    check("to_err_latency", err_cyc - req_cyc, TO);
    wait_busy_low(GAP + 100, low_cyc);
    check("to_gap", low_cyc - err_cyc, GAP);
    wait_idle(500);
    check("to_bytes", wr_cnt - base, 1);
    check("to_streaming", {31'd0, streaming}, 32'd1);
    check("to_no_done", done_cnt - w, 0);
    check("to_q_empty", exp_q.size(), 0);
    dead = 1'b0;

    // Reset during WAIT_DONE of byte 2 of START
    base = wr_cnt;
    push_bytes(2, 64'h452B0000_00000000);
    pulse(1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 500 && !(wr_cnt >= base + 2 && tx_busy === 1'b1); n++) tick();
    check("rst_mid_reached", {31'd0, tx_busy}, 32'd1);
    reset = 1'b1;
    tick();
    check_reset_outputs("rst_mid");
    tick();
    check("rst_mid_bytes", wr_cnt - base, 2);
    check("rst_mid_q_empty", exp_q.size(), 0);
    push_bytes(3, 64'h452D0A00_00000000);
    base = done_cnt;
    reset = 1'b0;
    wait_done(base + 1, 2000);
    wait_idle(2000);
    check("rst_mid_stop_done", done_cnt - base, 1);
    check("rst_mid_streaming", {31'd0, streaming}, 32'd0);
    check("rst_mid_stop_q_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
